// File: rtl/hdc_sim_pkg.sv
// rtl/hdc_sim_pkg.sv - shared constants and state type for the chunked HDC similarity sequencer
package hdc_sim_pkg;

  localparam int DIMENSIONS = 10000;
  localparam int CHUNK      = 500;
  localparam int MARGIN_THR = 100;
  localparam int NUM_CHUNKS = DIMENSIONS / CHUNK;
  localparam int DIST_W     = $clog2(DIMENSIONS + 1);
  localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    COMPARE = 2'd2
  } sim_state_t;

endpackage

// File: rtl/chunk_popcount.sv
// rtl/chunk_popcount.sv - combinational population count of one CHUNK-bit word
module chunk_popcount #(
  parameter int CHUNK = 500,
  localparam int CNT_W = $clog2(CHUNK + 1)
) (
  input  logic [CHUNK-1:0] i_word,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] w_sum;

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < CHUNK; i++) begin
      w_sum = w_sum + CNT_W'(i_word[i]);
    end
  end

  assign o_count = w_sum;

endmodule

// File: rtl/similarity_seq_ctrl.sv
// rtl/similarity_seq_ctrl.sv - Hamming-distance similarity sequenced in CHUNK-bit slices
// Optional margin/low_conf outputs are built when SIM_MARGIN_EN is defined.
module similarity_seq_ctrl
  import hdc_sim_pkg::sim_state_t, hdc_sim_pkg::IDLE, hdc_sim_pkg::ACCUM, hdc_sim_pkg::COMPARE;
#(
  parameter int DIMENSIONS = hdc_sim_pkg::DIMENSIONS,
  parameter int CHUNK      = hdc_sim_pkg::CHUNK,
  parameter int MARGIN_THR = hdc_sim_pkg::MARGIN_THR,
  localparam int NUM_CHUNKS = DIMENSIONS / CHUNK,
  localparam int DIST_W     = $clog2(DIMENSIONS + 1),
  localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1,
  localparam int CNT_W      = $clog2(CHUNK + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIMENSIONS-1:0] hv,
  input  logic [DIMENSIONS-1:0] ns_hv,
  input  logic [DIMENSIONS-1:0] s_hv,
`ifdef SIM_MARGIN_EN
  output logic [DIST_W-1:0]     margin,
  output logic                  low_conf,
`endif
  output logic                  out_valid,
  output logic                  label_out,
  output logic [DIST_W-1:0]     dist_ns,
  output logic [DIST_W-1:0]     dist_s
);

  if ((DIMENSIONS % CHUNK) != 0) begin : g_chunk_check
    $error("similarity_seq_ctrl: DIMENSIONS must be a multiple of CHUNK");
  end

  sim_state_t            r_state;
  logic [IDX_W-1:0]      r_idx;
  logic [DIMENSIONS-1:0] r_hv_q;
  logic [DIST_W-1:0]     r_acc_ns;
  logic [DIST_W-1:0]     r_acc_s;
  logic [DIST_W-1:0]     r_dist_ns;
  logic [DIST_W-1:0]     r_dist_s;
  logic                  r_label;
  logic                  r_out_valid;

  logic [CHUNK-1:0]      w_hv_chunk;
  logic [CHUNK-1:0]      w_ns_chunk;
  logic [CHUNK-1:0]      w_s_chunk;
  logic [CNT_W-1:0]      w_pc_ns;
  logic [CNT_W-1:0]      w_pc_s;
  logic                  w_last;

  assign w_hv_chunk = r_hv_q[r_idx*CHUNK +: CHUNK];
  assign w_ns_chunk = ns_hv[r_idx*CHUNK +: CHUNK];
  assign w_s_chunk  = s_hv[r_idx*CHUNK +: CHUNK];
  assign w_last     = (r_idx == IDX_W'(NUM_CHUNKS - 1));

  chunk_popcount #(.CHUNK(CHUNK)) u_pc_ns (
    .i_word  (w_hv_chunk ^ w_ns_chunk),
    .o_count (w_pc_ns)
  );

  chunk_popcount #(.CHUNK(CHUNK)) u_pc_s (
    .i_word  (w_hv_chunk ^ w_s_chunk),
    .o_count (w_pc_s)
  );

  // Distances are published one cycle after the last chunk; out_valid rises with them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_hv_q      <= '0;
      r_acc_ns    <= '0;
      r_acc_s     <= '0;
      r_dist_ns   <= '0;
      r_dist_s    <= '0;
      r_label     <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_hv_q   <= hv;
            r_idx    <= '0;
            r_acc_ns <= '0;
            r_acc_s  <= '0;
            r_state  <= ACCUM;
          end
        end
        ACCUM: begin
          r_acc_ns <= r_acc_ns + DIST_W'(w_pc_ns);
          r_acc_s  <= r_acc_s + DIST_W'(w_pc_s);
          if (w_last) begin
            r_idx   <= '0;
            r_state <= COMPARE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        COMPARE: begin
          r_dist_ns   <= r_acc_ns;
          r_dist_s    <= r_acc_s;
          r_label     <= (r_acc_s < r_acc_ns);
          r_out_valid <= 1'b1;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef SIM_MARGIN_EN
  logic [DIST_W-1:0] r_margin;
  logic              r_low_conf;
  logic [DIST_W-1:0] w_diff;

  assign w_diff = (r_acc_ns >= r_acc_s) ? (r_acc_ns - r_acc_s) : (r_acc_s - r_acc_ns);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_margin   <= '0;
      r_low_conf <= 1'b0;
    end else if (r_state == COMPARE) begin
      r_margin   <= w_diff;
      r_low_conf <= (w_diff < DIST_W'(MARGIN_THR));
    end
  end

  assign margin   = r_margin;
  assign low_conf = r_low_conf;
`endif

  assign in_ready  = (r_state == IDLE);
  assign out_valid = r_out_valid;
  assign label_out = r_label;
  assign dist_ns   = r_dist_ns;
  assign dist_s    = r_dist_s;

endmodule

// File: tb/tb_similarity_seq_ctrl.sv
// tb/tb_similarity_seq_ctrl.sv - self-checking bench for similarity_seq_ctrl
module tb_similarity_seq_ctrl;

  localparam int D       = 10000;
  localparam int DW      = 14;
  localparam int LATENCY = 21;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [D-1:0]  hv;
  logic [D-1:0]  ns_hv;
  logic [D-1:0]  s_hv;
  logic          out_valid;
  logic          label_out;
  logic [DW-1:0] dist_ns;
  logic [DW-1:0] dist_s;
`ifdef SIM_MARGIN_EN
  logic [DW-1:0] margin;
  logic          low_conf;
`endif

  int n_checks = 0;
  int n_errors = 0;

  similarity_seq_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .hv        (hv),
    .ns_hv     (ns_hv),
    .s_hv      (s_hv),
`ifdef SIM_MARGIN_EN
    .margin    (margin),
    .low_conf  (low_conf),
`endif
    .out_valid (out_valid),
    .label_out (label_out),
    .dist_ns   (dist_ns),
    .dist_s    (dist_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [D-1:0] low_ones(input int n);
    logic [D-1:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[i] = 1'b1;
    return v;
  endfunction

  // Transaction-level model: full-vector distances at accept, result due LATENCY edges later.
  int m_busy = 0, m_cnt = 0, m_valid = 0;
  int m_dns = 0, m_ds = 0, m_lab = 0, m_margin = 0, m_low = 0;
  int p_dns = 0, p_ds = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 0; m_cnt = 0; m_valid = 0;
      m_dns = 0; m_ds = 0; m_lab = 0; m_margin = 0; m_low = 0;
    end else begin
      m_valid = 0;
      if (m_busy != 0) begin
        m_cnt++;
        if (m_cnt == LATENCY) begin
          m_busy   = 0;
          m_valid  = 1;
          m_dns    = p_dns;
          m_ds     = p_ds;
          m_lab    = (p_ds < p_dns) ? 1 : 0;
          m_margin = (p_dns > p_ds) ? p_dns - p_ds : p_ds - p_dns;
          m_low    = (m_margin < 100) ? 1 : 0;
        end
      end else if (in_valid) begin
        p_dns  = $countones(hv ^ ns_hv);
        p_ds   = $countones(hv ^ s_hv);
        m_busy = 1;
        m_cnt  = 0;
      end
    end
    #1;
    check("cyc_in_ready", int'(in_ready), (m_busy == 0) ? 1 : 0);
    check("cyc_out_valid", int'(out_valid), m_valid);
    check("cyc_dist_ns", int'(dist_ns), m_dns);
    check("cyc_dist_s", int'(dist_s), m_ds);
    check("cyc_label", int'(label_out), m_lab);
`ifdef SIM_MARGIN_EN
    check("cyc_margin", int'(margin), m_margin);
    check("cyc_low_conf", int'(low_conf), m_low);
`endif
  end

  task automatic run_query(input string name, input logic [D-1:0] q,
                           input int e_dns, input int e_ds, input int e_lab,
                           input int e_margin, input int e_low);
    int lat;
    int found;
    hv = q;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    found = 0;
    for (int k = 0; k < 40 && found == 0; k++) begin
      @(negedge clk);
      lat++;
      if (out_valid) found = 1;
    end
    check({name, "_found"}, found, 1);
    check({name, "_latency"}, lat, LATENCY);
    check({name, "_dist_ns"}, int'(dist_ns), e_dns);
    check({name, "_dist_s"}, int'(dist_s), e_ds);
    check({name, "_label"}, int'(label_out), e_lab);
`ifdef SIM_MARGIN_EN
    check({name, "_margin"}, int'(margin), e_margin);
    check({name, "_low_conf"}, int'(low_conf), e_low);
`else
    if (e_margin < 0 || e_low < 0) check({name, "_margin_arg"}, e_margin, 0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int found;
    int seen;
    rst = 1'b1;
    in_valid = 1'b0;
    hv = '0;
    ns_hv = '0;
    s_hv = '1;
    repeat (3) @(negedge clk);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_dist_ns", int'(dist_ns), 0);
    check("rst_dist_s", int'(dist_s), 0);
    check("rst_label", int'(label_out), 0);
    rst = 1'b0;
    @(negedge clk);

    run_query("zeros", '0, 0, 10000, 0, 10000, 0);
    run_query("ones", '1, 10000, 0, 1, 10000, 0);
    run_query("tie", low_ones(5000), 5000, 5000, 0, 0, 1);
    run_query("one_bit", low_ones(1), 1, 9999, 0, 9998, 0);
    run_query("near", low_ones(4960), 4960, 5040, 0, 80, 1);
    run_query("s_wins", low_ones(6000), 6000, 4000, 1, 2000, 0);

    // in_valid held through the busy window while hv changes underneath
    hv = '0;
    in_valid = 1'b1;
    @(negedge clk);
    hv = '1;
    found = 0;
    for (int k = 0; k < 40 && found == 0; k++) begin
      @(negedge clk);
      if (out_valid) found = 1;
      else check("busy_in_ready", int'(in_ready), 0);
    end
    check("busy_found", found, 1);
    check("busy_first_dist_ns", int'(dist_ns), 0);
    check("busy_first_dist_s", int'(dist_s), 10000);
    check("busy_ready_after_result", int'(in_ready), 1);
    @(negedge clk);
    check("busy_second_accepted", int'(in_ready), 0);
    in_valid = 1'b0;
    lat = 1;
    found = 0;
    for (int k = 0; k < 40 && found == 0; k++) begin
      @(negedge clk);
      lat++;
      if (out_valid) found = 1;
    end
    check("busy_second_found", found, 1);
    check("busy_second_spacing", lat, LATENCY + 1);
    check("busy_second_dist_ns", int'(dist_ns), 10000);
    check("busy_second_label", int'(label_out), 1);

    // reset while chunk index 10 is being accumulated
    hv = '0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_dist_ns", int'(dist_ns), 0);
    check("abort_label", int'(label_out), 0);
    check("abort_in_ready", int'(in_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    check("abort_no_out_valid", seen, 0);
    check("abort_in_ready_after", int'(in_ready), 1);
    check("abort_dist_s", int'(dist_s), 0);

    run_query("recover", low_ones(6000), 6000, 4000, 1, 2000, 0);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
